// File: rtl/spi_pkg.sv
// Shared types and default parameters for the SPI write-only master.
package spi_pkg;

    // Default configuration matches the existing OLED panel.
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_CLK_DIV = 1;
    localparam int unsigned DEF_CPOL    = 1;
    localparam int unsigned DEF_CS_HOLD = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LEAD,
        TRAIL,
        GAP,
        HOLD
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Phase timer for the SPI master: emits a one-cycle phase_end tick every CLK_DIV cycles.
// restart forces the count back to zero so a freshly entered phase lasts exactly CLK_DIV cycles.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase_end
);

    localparam int unsigned DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    assign phase_end = (div_cnt == DIV_LAST);

    // Count cycles within a phase; reload on every phase boundary or explicit restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (restart || phase_end) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_tx_master.sv
// Parametrised SPI write-only master: streams DATA_W-bit words MSB-first with cs_n framing.
// Back-to-back words keep cs_n low; a word flagged tx_last releases cs_n after CS_HOLD cycles.
// Optional feature macro SPI_DC_EN adds the OLED data/command pin (tx_dc in, dc out).
module spi_tx_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned CPOL    = DEF_CPOL,
    parameter int unsigned CS_HOLD = DEF_CS_HOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
`ifdef SPI_DC_EN
    input  logic              tx_dc,
    output logic              dc,
`endif
    output logic              done
);

    localparam logic CPOL_BIT = (CPOL != 0);
    localparam int unsigned BW = $clog2(DATA_W + 1);
    localparam int unsigned HW = $clog2(CS_HOLD + 1);
    localparam logic [BW-1:0] BITS      = BW'(DATA_W);
    localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

    state_t            state;
    logic [DATA_W-1:0] shift_q;
    logic [BW-1:0]     bit_cnt;
    logic [HW-1:0]     hold_cnt;
    logic              last_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              cs_n_q;
    logic              done_q;
    logic              accept;
    logic              phase_end;

    assign tx_ready = (state == IDLE) || (state == GAP);
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign done     = done_q;

    // Every accepted word starts a fresh phase; other phase changes follow phase_end.
    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (accept),
        .phase_end (phase_end)
    );

`ifdef SPI_DC_EN
    logic dc_q;
    assign dc = dc_q;

    // Latch the data/command flag with each word so it stays stable for the whole word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_q <= 1'b0;
        end else if (accept) begin
            dc_q <= tx_dc;
        end
    end
`endif

    // Main FSM with registered serial outputs, shift register and bit/hold counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            last_q   <= 1'b0;
            sclk_q   <= CPOL_BIT;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx_valid) begin
                        state   <= SETUP;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= CPOL_BIT;
                        shift_q <= tx_data;
                        mosi_q  <= tx_data[DATA_W-1];
                        last_q  <= tx_last;
                        bit_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        state  <= LEAD;
                        sclk_q <= ~CPOL_BIT;
                        mosi_q <= shift_q[DATA_W-1];
                    end
                end
                LEAD: begin
                    // Trailing edge next: the slave samples mosi here.
                    if (phase_end) begin
                        state   <= TRAIL;
                        sclk_q  <= CPOL_BIT;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (phase_end) begin
                        if (bit_cnt < BITS) begin
                            state   <= LEAD;
                            sclk_q  <= ~CPOL_BIT;
                            shift_q <= shift_q << 1;
                            mosi_q  <= shift_q[DATA_W-2];
                        end else begin
                            done_q   <= 1'b1;
                            hold_cnt <= '0;
                            state    <= last_q ? HOLD : GAP;
                        end
                    end
                end
                GAP: begin
                    // Next word of the burst skips SETUP; mosi was already stable here.
                    if (tx_valid) begin
                        state   <= LEAD;
                        sclk_q  <= ~CPOL_BIT;
                        shift_q <= tx_data;
                        mosi_q  <= tx_data[DATA_W-1];
                        last_q  <= tx_last;
                        bit_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state  <= IDLE;
                        cs_n_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_master.sv
// Directed bench for spi_tx_master: an 8-bit CPOL=1 instance (a_*) and a 16-bit CPOL=0,
// CLK_DIV=3 instance (b_*), each observed by a small slave model sampling on clk negedges.
module tb_spi_tx_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Instance A: DATA_W=8, CLK_DIV=1, CPOL=1, CS_HOLD=1
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] a_data  = '0;
    logic       a_last  = 1'b0;
    logic       a_sclk, a_mosi, a_cs_n, a_busy, a_done;
`ifdef SPI_DC_EN
    logic       a_dc_in = 1'b0;
    logic       a_dc;
`endif

    spi_tx_master #(
        .DATA_W  (8),
        .CLK_DIV (1),
        .CPOL    (1),
        .CS_HOLD (1)
    ) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (a_valid),
        .tx_ready (a_ready),
        .tx_data  (a_data),
        .tx_last  (a_last),
        .sclk     (a_sclk),
        .mosi     (a_mosi),
        .cs_n     (a_cs_n),
        .busy     (a_busy),
`ifdef SPI_DC_EN
        .tx_dc    (a_dc_in),
        .dc       (a_dc),
`endif
        .done     (a_done)
    );

    // Instance B: DATA_W=16, CLK_DIV=3, CPOL=0, CS_HOLD=1
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [15:0] b_data  = '0;
    logic        b_last  = 1'b0;
    logic        b_sclk, b_mosi, b_cs_n, b_busy, b_done;
`ifdef SPI_DC_EN
    logic        b_dc;
`endif

    spi_tx_master #(
        .DATA_W  (16),
        .CLK_DIV (3),
        .CPOL    (0),
        .CS_HOLD (1)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (b_valid),
        .tx_ready (b_ready),
        .tx_data  (b_data),
        .tx_last  (b_last),
        .sclk     (b_sclk),
        .mosi     (b_mosi),
        .cs_n     (b_cs_n),
        .busy     (b_busy),
`ifdef SPI_DC_EN
        .tx_dc    (1'b0),
        .dc       (b_dc),
`endif
        .done     (b_done)
    );

    // Slave model A: captures on rising sclk (trailing edge for CPOL=1).
    logic [7:0] a_rx [0:63];
    int   a_rx_n = 0, a_bits = 0, a_done_n = 0, a_csl_n = 0, a_gap_n = 0, a_mosi_bad = 0;
    logic [7:0] a_sh = '0;
    logic a_p_sclk = 1'b1, a_p_cs_n = 1'b1, a_p_mosi = 1'b0;
`ifdef SPI_DC_EN
    logic a_rx_dc [0:63];
    logic a_first_dc = 1'b0, a_p_dc = 1'b0;
    int   a_dc_bad = 0;
`endif

    always @(negedge clk) begin
        if (!rst_n) begin
            a_bits = 0;
        end else if (!a_p_cs_n && !a_cs_n && !a_p_sclk && a_sclk) begin
            if (a_mosi !== a_p_mosi) a_mosi_bad++;
`ifdef SPI_DC_EN
            if (a_dc !== a_p_dc) a_dc_bad++;
            if (a_bits == 0) a_first_dc = a_dc;
            else if (a_dc !== a_first_dc) a_dc_bad++;
`endif
            a_sh = {a_sh[6:0], a_mosi};
            a_bits++;
            if (a_bits == 8) begin
                if (a_rx_n < 64) begin
                    a_rx[a_rx_n] = a_sh;
`ifdef SPI_DC_EN
                    a_rx_dc[a_rx_n] = a_first_dc;
`endif
                end
                a_rx_n++;
                a_bits = 0;
            end
        end
        if (a_done) a_done_n++;
        if (!a_cs_n) a_csl_n++;
        if (a_ready && !a_cs_n) a_gap_n++;
        a_p_sclk = a_sclk;
        a_p_cs_n = a_cs_n;
        a_p_mosi = a_mosi;
`ifdef SPI_DC_EN
        a_p_dc = a_dc;
`endif
    end

    // Slave model B: captures on falling sclk; also measures sclk high run lengths.
    logic [15:0] b_rx [0:15];
    int   b_rx_n = 0, b_bits = 0, b_done_n = 0, b_csl_n = 0, b_mosi_bad = 0;
    int   b_hi = 0, b_runs = 0, b_run_bad = 0;
    logic [15:0] b_sh = '0;
    logic b_p_sclk = 1'b0, b_p_cs_n = 1'b1, b_p_mosi = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            b_bits = 0;
        end else if (!b_p_cs_n && !b_cs_n && b_p_sclk && !b_sclk) begin
            if (b_mosi !== b_p_mosi) b_mosi_bad++;
            b_sh = {b_sh[14:0], b_mosi};
            b_bits++;
            if (b_bits == 16) begin
                if (b_rx_n < 16) b_rx[b_rx_n] = b_sh;
                b_rx_n++;
                b_bits = 0;
            end
        end
        if (!b_cs_n && b_sclk) begin
            b_hi++;
        end else if (b_hi != 0) begin
            b_runs++;
            if (b_hi != 3) b_run_bad++;
            b_hi = 0;
        end
        if (b_done) b_done_n++;
        if (!b_cs_n) b_csl_n++;
        b_p_sclk = b_sclk;
        b_p_cs_n = b_cs_n;
        b_p_mosi = b_mosi;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one word to A and return #1 after the accepting edge with valid dropped.
    task automatic send_a(input logic [7:0] d, input logic last);
        int n;
        a_valid = 1'b1;
        a_data  = d;
        a_last  = last;
        n = 0;
        while (!a_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("a_ready_wait", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

`ifdef SPI_DC_EN
    task automatic send_a_dc(input logic dcv, input logic [7:0] d, input logic last);
        a_dc_in = dcv;
        send_a(d, last);
    endtask
`endif

    task automatic send_b(input logic [15:0] d, input logic last);
        int n;
        b_valid = 1'b1;
        b_data  = d;
        b_last  = last;
        n = 0;
        while (!b_ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("b_ready_wait", 32'(b_ready), 32'd1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (a_busy && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("a_idle_wait", 32'(a_busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_b();
        int n = 0;
        while (b_busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("b_idle_wait", 32'(b_busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    int rx0, dn0, cs0, gp0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check_val("rst_a_sclk",  32'(a_sclk),  32'd1);
        check_val("rst_a_mosi",  32'(a_mosi),  32'd0);
        check_val("rst_a_cs_n",  32'(a_cs_n),  32'd1);
        check_val("rst_a_done",  32'(a_done),  32'd0);
        check_val("rst_a_busy",  32'(a_busy),  32'd0);
        check_val("rst_a_ready", 32'(a_ready), 32'd1);
        check_val("rst_b_sclk",  32'(b_sclk),  32'd0);
        check_val("rst_b_cs_n",  32'(b_cs_n),  32'd1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: single word A5
        rx0 = a_rx_n; dn0 = a_done_n; cs0 = a_csl_n;
        send_a(8'hA5, 1'b1);
        check_val("t1_setup_cs_n", 32'(a_cs_n), 32'd0);
        check_val("t1_setup_mosi", 32'(a_mosi), 32'd1);
        wait_idle_a();
        check_val("t1_words", 32'(a_rx_n - rx0), 32'd1);
        check_val("t1_data",  32'(a_rx[rx0]), 32'hA5);
        check_val("t1_done",  32'(a_done_n - dn0), 32'd1);
        check_val("t1_cs_low", 32'(a_csl_n - cs0), 32'd18);
        check_val("t1_cs_end", 32'(a_cs_n), 32'd1);

        // 2: burst 01,80,FF with valid held
        rx0 = a_rx_n; dn0 = a_done_n; cs0 = a_csl_n; gp0 = a_gap_n;
        send_a(8'h01, 1'b0);
        send_a(8'h80, 1'b0);
        send_a(8'hFF, 1'b1);
        wait_idle_a();
        check_val("t2_words", 32'(a_rx_n - rx0), 32'd3);
        check_val("t2_w0", 32'(a_rx[rx0]),     32'h01);
        check_val("t2_w1", 32'(a_rx[rx0 + 1]), 32'h80);
        check_val("t2_w2", 32'(a_rx[rx0 + 2]), 32'hFF);
        check_val("t2_done", 32'(a_done_n - dn0), 32'd3);
        check_val("t2_cs_low", 32'(a_csl_n - cs0), 32'd52);
        check_val("t2_gaps", 32'(a_gap_n - gp0), 32'd2);

        // 3: burst with a 5-cycle stall in GAP
        rx0 = a_rx_n; dn0 = a_done_n;
        send_a(8'h11, 1'b0);
        begin
            int n = 0;
            while (!a_ready && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        repeat (5) @(posedge clk);
        #1;
        check_val("t3_gap_sclk",  32'(a_sclk),  32'd1);
        check_val("t3_gap_cs_n",  32'(a_cs_n),  32'd0);
        check_val("t3_gap_ready", 32'(a_ready), 32'd1);
        check_val("t3_gap_mosi",  32'(a_mosi),  32'd1);
        check_val("t3_gap_done",  32'(a_done),  32'd0);
        send_a(8'h22, 1'b1);
        wait_idle_a();
        check_val("t3_words", 32'(a_rx_n - rx0), 32'd2);
        check_val("t3_w0", 32'(a_rx[rx0]),     32'h11);
        check_val("t3_w1", 32'(a_rx[rx0 + 1]), 32'h22);
        check_val("t3_done", 32'(a_done_n - dn0), 32'd2);

        // 4: 16-bit word on B, CPOL=0, CLK_DIV=3
        send_b(16'h1234, 1'b1);
        wait_idle_b();
        check_val("t4_words", 32'(b_rx_n), 32'd1);
        check_val("t4_data",  32'(b_rx[0]), 32'h1234);
        check_val("t4_done",  32'(b_done_n), 32'd1);
        check_val("t4_cs_low", 32'(b_csl_n), 32'd100);
        check_val("t4_hi_runs", 32'(b_runs), 32'd16);
        check_val("t4_hi_bad",  32'(b_run_bad), 32'd0);
        check_val("t4_idle_sclk", 32'(b_sclk), 32'd0);

        // 5: asynchronous reset in the middle of 3C, then C3 intact
        rx0 = a_rx_n; dn0 = a_done_n;
        send_a(8'h3C, 1'b1);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_sclk",  32'(a_sclk),  32'd1);
        check_val("t5_rst_cs_n",  32'(a_cs_n),  32'd1);
        check_val("t5_rst_mosi",  32'(a_mosi),  32'd0);
        check_val("t5_rst_done",  32'(a_done),  32'd0);
        check_val("t5_rst_busy",  32'(a_busy),  32'd0);
        check_val("t5_rst_ready", 32'(a_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("t5_no_done", 32'(a_done_n - dn0), 32'd0);
        send_a(8'hC3, 1'b1);
        wait_idle_a();
        check_val("t5_words", 32'(a_rx_n - rx0), 32'd1);
        check_val("t5_data",  32'(a_rx[rx0]), 32'hC3);
        check_val("t5_done",  32'(a_done_n - dn0), 32'd1);

`ifdef SPI_DC_EN
        // 6: data/command flag follows each word of a burst
        rx0 = a_rx_n;
        send_a_dc(1'b0, 8'hAE, 1'b0);
        check_val("t6_dc_setup", 32'(a_dc), 32'd0);
        send_a_dc(1'b1, 8'h55, 1'b1);
        check_val("t6_dc_word2", 32'(a_dc), 32'd1);
        wait_idle_a();
        check_val("t6_w0", 32'(a_rx[rx0]),     32'hAE);
        check_val("t6_w1", 32'(a_rx[rx0 + 1]), 32'h55);
        check_val("t6_dc0", 32'(a_rx_dc[rx0]),     32'd0);
        check_val("t6_dc1", 32'(a_rx_dc[rx0 + 1]), 32'd1);
        check_val("t6_dc_stable", 32'(a_dc_bad), 32'd0);
`endif

        // mosi must never move across a trailing edge
        check_val("a_mosi_stable", 32'(a_mosi_bad), 32'd0);
        check_val("b_mosi_stable", 32'(b_mosi_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
